// File: rtl/output_mem_control.sv
// Write-side controller for the systolic result path: turns a diagonally skewed
// result wavefront into per-bank write strobes and row addresses.
module output_mem_control #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_active,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic [DIM_W-1:0]          i_num_row,
  input  logic [DIM_W-1:0]          i_num_col,
  output logic [WIDTH-1:0]          o_wr_en,
  output logic [WIDTH*ADDR_W-1:0]   o_out_addr,
  output logic                      o_done
);
  localparam int CNT_W = DIM_W + 1;
  localparam logic [DIM_W-1:0] W_MAX = DIM_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_W-1:0]         r_base;
  logic [DIM_W-1:0]          r_rows, r_cols;
  logic [WIDTH-1:0]          r_wr_en;
  logic [WIDTH*ADDR_W-1:0]   r_addr;
  logic                      r_done;

  logic [DIM_W-1:0]          w_rows_in, w_cols_in, w_rows, w_cols;
  logic [ADDR_W-1:0]         w_base;
  logic [CNT_W-1:0]          w_cnt, w_last;
  logic [WIDTH-1:0]          w_wr_en;
  logic [WIDTH*ADDR_W-1:0]   w_addr;

  // In IDLE the cnt=0 outputs are computed straight from the inputs so the
  // first strobe lands one cycle after the active sample.
  always_comb begin
    w_rows_in = (i_num_row > W_MAX) ? W_MAX : i_num_row;
    w_cols_in = (i_num_col > W_MAX) ? W_MAX : i_num_col;
    if (r_state == S_IDLE) begin
      w_cnt  = '0;
      w_base = i_base_addr;
      w_rows = w_rows_in;
      w_cols = w_cols_in;
    end else begin
      w_cnt  = r_cnt;
      w_base = r_base;
      w_rows = r_rows;
      w_cols = r_cols;
    end
    w_last  = {1'b0, r_rows} + {1'b0, r_cols} - CNT_W'(1);
    w_wr_en = '0;
    w_addr  = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if ((CNT_W'(c) < {1'b0, w_cols}) && (w_cnt >= CNT_W'(c)) &&
          ((w_cnt - CNT_W'(c)) < {1'b0, w_rows})) begin
        w_wr_en[c] = 1'b1;
        w_addr[c*ADDR_W +: ADDR_W] = w_base + ADDR_W'(w_cnt - CNT_W'(c));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_rows  <= '0;
      r_cols  <= '0;
      r_wr_en <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_wr_en <= '0;
          r_addr  <= '0;
          if (i_active) begin
            r_base <= i_base_addr;
            r_rows <= w_rows_in;
            r_cols <= w_cols_in;
            if (w_rows_in == '0 || w_cols_in == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_wr_en <= w_wr_en;
              r_addr  <= w_addr;
              r_cnt   <= CNT_W'(1);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // r_cnt runs one ahead of the outputs; reaching rows+cols-1 means
          // the last diagonal has already been issued.
          if (r_cnt == w_last) begin
            r_wr_en <= '0;
            r_addr  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wr_en <= w_wr_en;
            r_addr  <= w_addr;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_wr_en <= '0;
          r_addr  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_out_addr = r_addr;
  assign o_done     = r_done;
endmodule

// File: doc/output_mem_control.md
Name: output_mem_control

Overview:
Write-side memory controller for the systolic array's result path. It is the counterpart of the read-side master memory control, which issues skewed read addresses into the array. On an `active` pulse it latches a base address and the result tile dimensions. It then issues per-bank write enables and 8-bit write addresses so that the diagonally skewed result wavefront from the array bottom lands row-by-row in the output memory banks. It pulses `done` when the tile is fully written.

Parameters:
- WIDTH, 16: number of array columns / output memory banks.
- ADDR_W, 8: per-bank address width.
- DIM_W, 5: width of num_row/num_col; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- active  input  1  start pulse; sampled only in IDLE.
- base_addr  input  ADDR_W  first row address written in every bank.
- num_row  input  DIM_W  result rows to write, legal 1..WIDTH.
- num_col  input  DIM_W  result columns (banks) used, legal 1..WIDTH.
- wr_en  output  WIDTH  bit c = write strobe for bank c.
- out_addr  output  WIDTH*ADDR_W  bank c address at bits [ADDR_W*c+ADDR_W-1 : ADDR_W*c].
- done  output  1  one-cycle pulse after the last write.

Behaviour:
- All outputs are registered. Reset drives wr_en=0, out_addr=0, done=0 and state=IDLE.
- Reset wins over every other input in the same cycle, including mid-RUN. An aborted tile never produces `done`.
- State IDLE:
  - On active=1, latch base_addr, num_row, num_col.
  - Clamp num_row and num_col to WIDTH if greater.
  - If either latched value is 0, go to DONE directly; no writes occur.
  - Otherwise clear cycle counter cnt=0 and go to RUN.
- State RUN:
  - Registered outputs for counter value cnt are valid in the following cycle. The first write strobe appears in the cycle after `active` is sampled (latency 1).
  - Bank c writes when: c < num_col, cnt >= c, and (cnt - c) < num_row.
  - Bank c address = base_addr + (cnt - c), modulo 2^ADDR_W. Wrap-around past 0xFF is legal and silent.
  - Address field is 0 for any bank whose wr_en bit is 0.
  - cnt increments every cycle. Leave RUN after cnt = num_row + num_col - 2, so RUN spans num_row + num_col - 1 cycles of output.
- State DONE:
  - Lasts exactly one cycle, with done=1 and wr_en=0.
  - Then return to IDLE.
  - Total: the done pulse appears num_row + num_col cycles after the `active` sample. For zero dimensions, done appears 1 cycle after.
- `active` is ignored in RUN and DONE; no queuing. Input changes during RUN have no effect because values were latched.
- A new tile is accepted in the first IDLE cycle after DONE. Back-to-back tiles therefore have one dead cycle between them.
- cnt is wide enough for 2*WIDTH-2.

Test Plan:
- Basic skew: reset, then base=0x10, rows=4, cols=3, active pulse.
  - wr_en over 6 cycles = 001, 011, 111, 111, 110, 100.
  - Bank0 addrs 10,11,12,13; bank1 addrs 10..13 one cycle later; bank2 two cycles later.
  - done=1 in the 7th cycle after the active sample, then idle.
- Full tile: base=0x00, rows=16, cols=16.
  - 31 write cycles; bank15 first write in cycle 16 at addr 0x00, last at 0x0F.
  - wr_en=0xFFFF only in cycle 16; done in cycle 32.
- Wrap: base=0xFE, rows=4, cols=1 → bank0 addrs FE, FF, 00, 01; done in cycle 5.
- Edge sizes:
  - rows=0, cols=5 → no wr_en; done 1 cycle after active.
  - rows=20 → behaves as 16.
- Busy/abort:
  - Pulse active again and change base_addr during RUN → no effect on the sequence.
  - Separate run: assert reset in cycle 3 of RUN → next cycle all outputs 0, no done.
  - A fresh active afterwards starts a clean tile.
- Back-to-back: second active held high through DONE → new tile starts from the IDLE cycle after DONE, with correct addresses.
